// File: rtl/button_event_scheduler.sv
// Turns debounced button levels into an ordered stream of press events: one
// pending slot per button, round-robin arbitration onto a single valid/ready port.
module button_event_scheduler #(
    parameter  int width    = 4,
    localparam int id_width = (width > 1) ? $clog2(width) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [width-1:0]    debounced_signal,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [id_width-1:0] event_id,
    output logic                event_dropped
);

    // Handshake: an event transfers on a rising edge where event_valid && event_ready;
    // while event_valid is high and not accepted, event_valid and event_id stay constant.

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [width-1:0]    prev_q;
    logic [width-1:0]    pending_q, pending_d;
    logic [id_width-1:0] id_q, id_d;
    logic [id_width-1:0] last_q, last_d;
    logic                dropped_q, dropped_d;

    logic [width-1:0]    rise;
    logic [width-1:0]    clr;
    logic                found;
    logic                take;
    logic [id_width-1:0] sel;

    assign rise = debounced_signal & ~prev_q;

    // Round-robin: buttons above the last grant first, then wrap to 0..last.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < width; i++) begin
            if (!found && pending_q[i] && (i > int'(last_q))) begin
                found = 1'b1;
                sel   = id_width'(i);
            end
        end
        for (int i = 0; i < width; i++) begin
            if (!found && pending_q[i] && (i <= int'(last_q))) begin
                found = 1'b1;
                sel   = id_width'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        take    = 1'b0;
        clr     = '0;
        case (state_q)
            EMPTY: begin
                if (found) begin
                    take    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (event_ready) begin
                    if (found) take = 1'b1;
                    else       state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (take) begin
            id_d   = sel;
            last_d = sel;
            clr    = width'(1) << sel;
        end
        // A rise on the cycle its slot is granted refills the slot rather than dropping.
        pending_d = (pending_q & ~clr) | rise;
        dropped_d = |(rise & pending_q & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            prev_q    <= '1;
            pending_q <= '0;
            id_q      <= '0;
            last_q    <= id_width'(width - 1);
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= debounced_signal;
            pending_q <= pending_d;
            id_q      <= id_d;
            last_q    <= last_d;
            dropped_q <= dropped_d;
        end
    end

    assign event_valid   = (state_q == FULL);
    assign event_id      = id_q;
    assign event_dropped = dropped_q;

endmodule

// File: doc/button_event_scheduler.md
# button_event_scheduler

Sits behind the per-button `debouncer` instances and turns their debounced levels into a single ordered stream of press events. It detects a rising edge on each debounced line and queues one pending press per button. A round-robin arbiter shares one valid/ready output port among all buttons, so downstream FSMs (tone select, mode change) consume exactly one event per physical press, even when presses land on the same cycle.

## Interface
- `width`, 4: number of debounced button lines; legal range 1–16.
- `id_width`, `(width > 1) ? $clog2(width) : 1`: width of `event_id`; localparam, not overridable.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset; clears all state immediately.
- `debounced_signal`  in  `width`: debouncer outputs, already synchronous to `clk`.
- `event_valid`  out  1: an event is offered on `event_id`.
- `event_ready`  in  1: the consumer accepts the event when `event_valid && event_ready` at a rising edge.
- `event_id`  out  `id_width`: index of the pressed button.
- `event_dropped`  out  1: one-cycle pulse when a press is lost because that button's pending slot is full.

## Operation
- `prev` register (`width` bits), updated every cycle as `prev <= debounced_signal`. `rise = debounced_signal & ~prev`.
- `prev` resets to all ones, so a button held through reset release produces no event.
- `pending` register (`width` bits), one slot per button:
  - Set on `rise[i]`.
  - Cleared when button i is moved into the output register.
  - If the set and the clear happen in the same cycle, the set wins.
- Overflow: if `rise[i]` occurs while `pending[i]` is already 1, the new press is discarded. `event_dropped` is 1 for the next cycle. Drops on several buttons in the same cycle give a single pulse.
- Two-state FSM on the output register:
  - EMPTY: `event_valid = 0`. If `pending != 0`, grant one button. Load its index into `event_id`, clear its pending bit, go to FULL.
  - FULL: `event_valid = 1`. `event_id` is held stable until accepted.
  - FULL, on handshake with `pending != 0`: grant the next button in the same cycle and stay FULL (back-to-back events).
  - FULL, on handshake with `pending == 0`: go to EMPTY.
- Round-robin pointer `last`: search order is `last+1, last+2, …` wrapping modulo `width`. `last` updates only on a grant.
- A button sitting in the output register can be pending again at the same time. Each button can therefore hold at most 2 outstanding events.
- `event_valid` must never drop, and `event_id` must never change, while FULL and not accepted.

## Timing
- Reset values:
  - `event_valid = 0`, `event_id = 0`, `event_dropped = 0`.
  - `pending = 0`, `prev = all ones`, `last = width-1` (button 0 has top priority first), FSM state EMPTY.
- Latency: input rises before edge k → `pending` set at edge k → `event_valid` high after edge k+1. This is 2 cycles when the FSM is EMPTY.
- Throughput: 1 event per cycle while `event_ready` is held high and `pending != 0`.
- `event_dropped` asserts the cycle after the rejected rising edge.
- Reset asserted mid-offer: `event_valid` goes to 0 asynchronously and every queued event is discarded. After release, the first cycle compares against `prev = all ones`.
- No combinational path from `event_ready` to `event_valid` or `event_id`. All outputs are registered.

## Test plan
- Reset with button 2 held high, then release reset and hold button 2 high for 20 cycles → `event_valid` stays 0 throughout, `event_dropped` stays 0.
- Button 1 rises with `event_ready = 1` → `event_valid = 1` with `event_id = 1` for exactly 1 cycle, 2 cycles after the rise. After that, `event_valid = 0`.
- Buttons 0, 1 and 3 rise on the same cycle with `event_ready = 1` → ids 0, 1, 3 appear on consecutive cycles. A following simultaneous rise of buttons 0 and 3 yields 0 then 3: the pointer wraps past 3 back to 0.
- Hold `event_ready = 0`, press button 2 three times (rise, fall, rise, fall, rise) → `event_id = 2` is held stable and `pending[2] = 1`. The third rise produces exactly one `event_dropped` pulse. Releasing `event_ready` then yields exactly two id-2 events.
- Same-cycle set/clear: button 0 rises on the cycle its pending bit is granted → a second id-0 event is delivered later.
- Assert `rst` for 1 cycle while `event_valid = 1` with 3 events pending → `event_valid = 0` immediately, and no events follow after release.
